wb_burst_master: RTL and testbench
==================================

// Module: wb_burst_master
// PURPOSE
//  Wishbone B3 master that feeds the SDRAM memory_controller (wb_* slave port) from a simple command stream.
//  Turns one command {we, addr, len} into one incrementing Wishbone burst (CTI 010, final beat 111).
//  Write data enters and read data leaves through streaming handshakes.
//  Includes an ack watchdog, so a hung slave cannot lock the bus.
// PARAMETERS
//  dw       32    Wishbone data width; byte lanes = dw/8
//  APP_AW   26    Wishbone byte-address width
//  LEN_W    8     width of cmd_len (beats-1); max burst = 2**LEN_W beats
//  TIMEOUT  1024  cycles with stb high and no ack before the cycle is aborted (>=2)
// PORTS
//  wb_clk_i      in   1          system clock; all logic on its rising edge
//  wb_rst_i      in   1          asynchronous, active-high reset
//  cmd_valid     in   1          command offered
//  cmd_ready     out  1          command accepted when valid&ready
//  cmd_we        in   1          1=write burst, 0=read burst
//  cmd_addr      in   APP_AW     start byte address; low log2(dw/8) bits ignored (forced 0)
//  cmd_len       in   LEN_W      beats-1
//  cmd_sel       in   dw/8       byte select, applied to every beat
//  wr_valid      in   1          write word offered
//  wr_ready      out  1          write word accepted when valid&ready
//  wr_data       in   dw         write word
//  rd_valid      out  1          read word valid (no back-pressure; sink must take it)
//  rd_data       out  dw         read word
//  done          out  1          1-cycle pulse: burst completed normally
//  err_timeout   out  1          1-cycle pulse: burst aborted by watchdog
//  wb_cyc_o/wb_stb_o/wb_we_o  out 1  Wishbone control
//  wb_addr_o     out  APP_AW     Wishbone byte address
//  wb_dat_o      out  dw         Wishbone write data
//  wb_sel_o      out  dw/8       Wishbone byte select
//  wb_cti_o      out  3          Wishbone cycle type
//  wb_ack_i      in   1          Wishbone ack
//  wb_dat_i      in   dw         Wishbone read data
// BEHAVIOUR
//  Reset: every output is 0, except cmd_ready, which is 1. FSM=IDLE. Outputs take these values immediately on reset, mid-burst included; no done or err_timeout pulse is produced.
//  FSM: IDLE -> XFER on cmd_valid&cmd_ready; XFER -> DONE on ack of the last beat; XFER -> ABORT on watchdog expiry.
//       DONE and ABORT last one cycle each, then return to IDLE.
//  cmd_ready = (state==IDLE). After each burst, cyc stays low for >=2 cycles (DONE/ABORT plus IDLE).
//  On accept: register we, addr (aligned), sel. beats_left = len+1. loads_left = len+1 for writes.
//  XFER: wb_cyc_o=1 for the whole burst. wb_stb_o = we ? hold_v : 1.
//  Writes: a 1-word hold register feeds wb_dat_o.
//       wr_ready = XFER & we & loads_left!=0 & (!hold_v | ack).
//       A load sets hold_v and decrements loads_left. An ack with no same-cycle load clears hold_v.
//       A wr_valid gap drops stb with cyc held; no beat is lost or duplicated.
//  Each ack: beats_left-1. wb_addr_o += dw/8, modulo 2**APP_AW (wraps to 0).
//  wb_cti_o = 3'b111 when beats_left==1, else 3'b010. len=0 gives a single 111 beat.
//  A late or early ack while stb=0 is ignored.
//  Read: rd_valid/rd_data are registered; they are the ack & !we & stb of the previous cycle and wb_dat_i captured then (latency 1).
//  done is asserted in the DONE cycle, i.e. 1 cycle after the last ack.
//  Watchdog: counter clears on ack or stb=0 and increments while stb=1 & !ack.
//       At count==TIMEOUT-1 with no ack, the next state is ABORT. In ABORT: cyc=stb=0, err_timeout=1. Unsent write words remain in the source stream.
//  Simultaneous last ack and watchdog expiry: the ack wins (DONE).
//  wb_we_o, wb_sel_o and wb_addr_o are stable through the burst. They are 0 when cyc=0.
// STRUCTURE
//  Package sdr_wb_pkg holds:
//       CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111
//       typedef enum logic[1:0] {IDLE,XFER,DONE,ABORT} wbm_state_t
//  Sub-module wb_ack_watchdog (params TIMEOUT; ports clk, rst, active, ack, expire).
//  The rest is the single FSM plus the datapath in this module.
// TESTING (bench: memory_controller + mt48lc2m32b2, dw=32, APP_AW=26)
//  1. Write: len=3, addr=0x100, wr_data A0..A3 back-to-back.
//     -> 4 acks; addr 0x100/104/108/10C; cti 010,010,010,111; done 1 cycle after last ack.
//     Read back: same cmd, we=0 -> rd_data A0..A3 in order; exactly 4 rd_valid pulses.
//  2. len=1 at addr 0x3FFFFFC (write then read).
//     -> 2nd beat address 0x0000000; data round-trips; cti 010,111.
//  3. Write len=7 with wr_valid low for 3 cycles after beat 2.
//     -> stb low 3+ cycles, cyc high throughout, exactly 8 acks, memory holds all 8 words.
//  4. Stub slave withholds ack, TIMEOUT=16.
//     -> err_timeout pulse at 16th stb cycle+1, cyc/stb low, no done; cmd_ready=1 one cycle later.
//  5. Assert wb_rst_i during beat 2 of a read with len=7.
//     -> cyc/stb/rd_valid 0 in the same cycle (async), cmd_ready=1, no done/err.
//     After release, a new single write succeeds.
//  6. cmd_valid held for 3 queued len=0 commands.
//     -> cmd_ready pulses once per burst; >=2 idle cycles between cyc periods; 3 done pulses.

Source files
------------

// File: rtl/sdr_wb_pkg.sv
// Shared Wishbone cycle-type codes and burst-master state encoding.
package sdr_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {IDLE, XFER, DONE, ABORT} wbm_state_t;

endpackage

// File: rtl/wb_ack_watchdog.sv
// Counts consecutive strobe cycles without ack; flags expiry on the TIMEOUT-th such cycle.
// Combinational expire, one-cycle-early look-ahead so the FSM can leave on the following edge.
module wb_ack_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic ack,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active || ack) begin
      cnt <= '0;
    end else if (cnt != LIM) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = active & !ack & (cnt == LIM);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master driven by a {we, addr, len} command stream,
// with a one-word write hold register, registered read return and an ack watchdog.
module wb_burst_master
  import sdr_wb_pkg::*;
#(
  parameter int dw      = 32,
  parameter int APP_AW  = 26,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [APP_AW-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [dw/8-1:0]     cmd_sel,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [dw-1:0]       wr_data,
  output logic                rd_valid,
  output logic [dw-1:0]       rd_data,
  output logic                done,
  output logic                err_timeout,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [APP_AW-1:0]   wb_addr_o,
  output logic [dw-1:0]       wb_dat_o,
  output logic [dw/8-1:0]     wb_sel_o,
  output logic [2:0]          wb_cti_o,
  input  logic                wb_ack_i,
  input  logic [dw-1:0]       wb_dat_i
);

  localparam int SW = dw / 8;
  localparam logic [APP_AW-1:0] STEP  = APP_AW'(SW);
  localparam logic [APP_AW-1:0] AMASK = ~APP_AW'(SW - 1);
  localparam logic [LEN_W:0]    ONE   = (LEN_W + 1)'(1);

  wbm_state_t        state;
  logic              we_r;
  logic [APP_AW-1:0] addr_r;
  logic [SW-1:0]     sel_r;
  logic [LEN_W:0]    beats_left;
  logic [LEN_W:0]    loads_left;
  logic              hold_v;
  logic [dw-1:0]     hold_dat;

  logic xfer, ack, load, last, expire;

  assign xfer      = (state == XFER);
  assign last      = (beats_left == ONE);
  assign cmd_ready = (state == IDLE);

  // Address, select and direction are forced to zero outside the cycle.
  assign wb_cyc_o  = xfer;
  assign wb_stb_o  = xfer & (we_r ? hold_v : 1'b1);
  assign wb_we_o   = xfer & we_r;
  assign wb_addr_o = xfer ? addr_r : '0;
  assign wb_sel_o  = xfer ? sel_r : '0;
  assign wb_dat_o  = (xfer & we_r) ? hold_dat : '0;
  assign wb_cti_o  = !xfer ? CTI_CLASSIC : (last ? CTI_EOB : CTI_INCR);

  // An ack seen while stb is low belongs to nobody and is dropped here.
  assign ack      = wb_ack_i & wb_stb_o;
  assign wr_ready = xfer & we_r & (loads_left != '0) & (!hold_v | ack);
  assign load     = wr_valid & wr_ready;

  wb_ack_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .active (wb_stb_o),
    .ack    (wb_ack_i),
    .expire (expire)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      we_r        <= 1'b0;
      addr_r      <= '0;
      sel_r       <= '0;
      beats_left  <= '0;
      loads_left  <= '0;
      hold_v      <= 1'b0;
      hold_dat    <= '0;
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      done        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      done        <= 1'b0;
      err_timeout <= 1'b0;
      rd_valid    <= ack & !we_r;
      if (ack && !we_r) rd_data <= wb_dat_i;

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            we_r       <= cmd_we;
            addr_r     <= cmd_addr & AMASK;
            sel_r      <= cmd_sel;
            beats_left <= {1'b0, cmd_len} + ONE;
            loads_left <= cmd_we ? ({1'b0, cmd_len} + ONE) : '0;
            hold_v     <= 1'b0;
            state      <= XFER;
          end
        end
        XFER: begin
          // A load in the same cycle as an ack refills the hold slot, so hold_v stays set.
          if (load) begin
            hold_dat   <= wr_data;
            hold_v     <= 1'b1;
            loads_left <= loads_left - ONE;
          end else if (ack) begin
            hold_v <= 1'b0;
          end
          if (ack) begin
            beats_left <= beats_left - ONE;
            addr_r     <= addr_r + STEP;
          end
          if (ack && last) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (expire) begin
            state       <= ABORT;
            err_timeout <= 1'b1;
          end
        end
        DONE, ABORT: begin
          hold_v <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master against a combinational-ack stub slave with a word memory.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [25:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_sel = '0;
  logic        wr_valid = 1'b0, wr_ready;
  logic [31:0] wr_data = '0;
  logic        rd_valid, done, err_timeout;
  logic [31:0] rd_data;
  logic        wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;

  always #5 clk = ~clk;

  wb_burst_master #(.dw(32), .APP_AW(26), .LEN_W(8), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err_timeout(err_timeout),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  // Stub slave: acks every strobed cycle when enabled, word memory indexed by addr[9:2].
  logic [31:0] mem [256];
  logic        ack_en = 1'b1;
  assign wb_ack_i = ack_en & wb_cyc_o & wb_stb_o;
  assign wb_dat_i = mem[wb_addr_o[9:2]];
  always @(posedge clk) if (wb_ack_i && wb_we_o) mem[wb_addr_o[9:2]] <= wb_dat_o;

  // Monitor: absolute logs and counters; the test reads deltas from snapshots.
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [25:0] a_addr[$];
  logic [2:0]  a_cti[$];
  logic        a_we[$];
  logic [3:0]  a_sel[$];
  logic [31:0] a_dat[$];
  logic [31:0] rd_q[$];
  int          gap_q[$];
  int          stb_rise_q[$];
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0, last_ack_cyc = 0;
  int stb_low_cnt = 0, cyc_periods = 0, gap = 0, acc_cnt = 0, idle_viol = 0;
  logic [2:0] err_snap = '0;
  logic prev_cyc = 1'b0, prev_stb = 1'b0;

  always @(negedge clk) begin
    if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
      a_addr.push_back(wb_addr_o); a_cti.push_back(wb_cti_o); a_we.push_back(wb_we_o);
      a_sel.push_back(wb_sel_o); a_dat.push_back(wb_dat_o);
      last_ack_cyc <= cyc_n;
    end
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc_n; end
    if (err_timeout) begin
      err_cnt <= err_cnt + 1; err_cyc <= cyc_n;
      err_snap <= {wb_cyc_o, wb_stb_o, cmd_ready};
    end
    if (wb_cyc_o && !wb_stb_o) stb_low_cnt <= stb_low_cnt + 1;
    if (wb_stb_o && !prev_stb) stb_rise_q.push_back(cyc_n);
    if (wb_cyc_o && !prev_cyc) begin
      gap_q.push_back(gap);
      cyc_periods <= cyc_periods + 1;
    end
    gap <= wb_cyc_o ? 0 : gap + 1;
    if (cmd_valid && cmd_ready) acc_cnt <= acc_cnt + 1;
    if (!wb_cyc_o && (wb_stb_o || wb_we_o || wb_addr_o != '0 || wb_sel_o != '0 ||
                      wb_cti_o != '0 || wb_dat_o != '0)) idle_viol <= idle_viol + 1;
    prev_cyc <= wb_cyc_o;
    prev_stb <= wb_stb_o;
  end

  int n_cmp = 0, n_bad = 0;
  int b_ack, b_rd, b_done, b_err, b_stblow, b_per, b_acc, b_viol, b_gap, b_stbr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic snap();
    b_ack = a_addr.size(); b_rd = rd_q.size(); b_done = done_cnt; b_err = err_cnt;
    b_stblow = stb_low_cnt; b_per = cyc_periods; b_acc = acc_cnt; b_viol = idle_viol;
    b_gap = gap_q.size(); b_stbr = stb_rise_q.size();
  endtask

  // Call at posedge+1. outcome: 0 done, 1 err_timeout, 2 cycle budget expired.
  task automatic run_burst(input logic we, input logic [25:0] addr, input logic [7:0] len,
                           input logic [3:0] sel, input logic [31:0] base,
                           input int gap_at, input int gap_n, output int outcome);
    int   idx, gapc;
    logic acc, hs_c, hs_w, f_d, f_e, in_gap;
    idx = 0; gapc = 0; acc = 1'b0; outcome = 2;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = sel;
    for (int c = 0; c < 200; c++) begin
      in_gap   = acc && (idx == gap_at) && (gapc < gap_n);
      wr_valid = we && acc && (idx <= int'(len)) && !in_gap;
      wr_data  = base + 32'(idx);
      @(negedge clk);
      hs_c = cmd_valid & cmd_ready; hs_w = wr_valid & wr_ready;
      f_d = done; f_e = err_timeout;
      @(posedge clk); #1;
      if (hs_c) begin acc = 1'b1; cmd_valid = 1'b0; end
      if (hs_w) idx++;
      if (in_gap) gapc++;
      if (f_d) begin outcome = 0; break; end
      if (f_e) begin outcome = 1; break; end
    end
    cmd_valid = 1'b0; wr_valid = 1'b0;
  endtask

  task automatic compare_burst(input logic we, input logic [25:0] addr, input logic [7:0] len,
                               input logic [3:0] sel, input logic [31:0] base);
    logic [25:0] a;
    check("ack count", 32'(a_addr.size() - b_ack), 32'(len) + 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (b_ack + i < a_addr.size()) begin
        a = (addr & ~26'h3) + 26'(4 * i);
        check($sformatf("beat%0d addr", i), 32'(a_addr[b_ack + i]), 32'(a));
        check($sformatf("beat%0d cti", i), 32'(a_cti[b_ack + i]), (i == int'(len)) ? 32'h7 : 32'h2);
        check($sformatf("beat%0d we", i), 32'(a_we[b_ack + i]), 32'(we));
        check($sformatf("beat%0d sel", i), 32'(a_sel[b_ack + i]), 32'(sel));
        if (we) check($sformatf("beat%0d wdata", i), a_dat[b_ack + i], base + 32'(i));
      end
    end
    if (!we) begin
      check("rd_valid count", 32'(rd_q.size() - b_rd), 32'(len) + 1);
      for (int i = 0; i <= int'(len); i++)
        if (b_rd + i < rd_q.size())
          check($sformatf("rd_data%0d", i), rd_q[b_rd + i], base + 32'(i));
    end
    check("done pulses", 32'(done_cnt - b_done), 32'd1);
    check("done latency", 32'(done_cyc - last_ack_cyc), 32'd1);
    check("no err pulse", 32'(err_cnt - b_err), 32'd0);
    check("idle outputs zero", 32'(idle_viol - b_viol), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [7:0]  len;
    logic [3:0]  sel;
    logic [31:0] base;
    logic [25:0] exp_a0;
    logic [25:0] exp_a1;
  } vec_t;

  vec_t vt[6];
  int   outcome;
  int   acc;
  logic hs;

  initial begin
    vt[0] = '{1'b1, 26'h0000100, 8'd3, 4'hF, 32'hA0, 26'h0000100, 26'h0000104};
    vt[1] = '{1'b0, 26'h0000100, 8'd3, 4'hF, 32'hA0, 26'h0000100, 26'h0000104};
    vt[2] = '{1'b1, 26'h3FFFFFC, 8'd1, 4'hF, 32'hB0, 26'h3FFFFFC, 26'h0000000};
    vt[3] = '{1'b0, 26'h3FFFFFE, 8'd1, 4'hF, 32'hB0, 26'h3FFFFFC, 26'h0000000};
    vt[4] = '{1'b1, 26'h0000200, 8'd0, 4'hF, 32'hC0, 26'h0000200, 26'h0000000};
    vt[5] = '{1'b0, 26'h0000203, 8'd0, 4'h5, 32'hC0, 26'h0000200, 26'h0000000};

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset wb ctrl", 32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_cti_o}), 32'd0);
    check("reset wb addr/sel", 32'(wb_addr_o) | 32'(wb_sel_o), 32'd0);
    check("reset wb dat", wb_dat_o, 32'd0);
    check("reset pulses", 32'({rd_valid, done, err_timeout, wr_ready}), 32'd0);
    check("reset rd_data", rd_data, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      snap();
      run_burst(vt[k].we, vt[k].addr, vt[k].len, vt[k].sel, vt[k].base, -1, 0, outcome);
      check($sformatf("vec%0d outcome", k), 32'(outcome), 32'd0);
      if (b_ack < a_addr.size())
        check($sformatf("vec%0d first addr", k), 32'(a_addr[b_ack]), 32'(vt[k].exp_a0));
      if (vt[k].len != 8'd0 && b_ack + 1 < a_addr.size())
        check($sformatf("vec%0d second addr", k), 32'(a_addr[b_ack + 1]), 32'(vt[k].exp_a1));
      compare_burst(vt[k].we, vt[k].addr, vt[k].len, vt[k].sel, vt[k].base);
    end

    // Write len=7 with a 3-cycle wr_valid gap after beat 2.
    snap();
    run_burst(1'b1, 26'h300, 8'd7, 4'hF, 32'hE0, 3, 3, outcome);
    check("gap outcome", 32'(outcome), 32'd0);
    compare_burst(1'b1, 26'h300, 8'd7, 4'hF, 32'hE0);
    check("gap single cyc period", 32'(cyc_periods - b_per), 32'd1);
    check("gap stb low >=3", 32'((stb_low_cnt - b_stblow) >= 3), 32'd1);
    for (int i = 0; i < 8; i++)
      check($sformatf("gap mem%0d", i), mem[8'hC0 + 8'(i)], 32'hE0 + 32'(i));

    // Slave withholds ack: watchdog abort after 16 strobe cycles.
    snap();
    ack_en = 1'b0;
    run_burst(1'b0, 26'h0, 8'd3, 4'hF, 32'h0, -1, 0, outcome);
    check("timeout outcome", 32'(outcome), 32'd1);
    check("timeout err pulses", 32'(err_cnt - b_err), 32'd1);
    check("timeout no done", 32'(done_cnt - b_done), 32'd0);
    if (b_stbr < stb_rise_q.size())
      check("timeout err cycle", 32'(err_cyc - stb_rise_q[b_stbr]), 32'd16);
    check("timeout abort cycle cyc/stb/rdy", 32'(err_snap), 32'd0);
    check("timeout cmd_ready after", 32'(cmd_ready), 32'd1);
    ack_en = 1'b1;
    @(posedge clk); #1;

    // Async reset during beat 2 of a len=7 read.
    snap();
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h100; cmd_len = 8'd7; cmd_sel = 4'hF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); hs = cmd_valid & cmd_ready;
      @(posedge clk); #1;
      if (hs) break;
    end
    cmd_valid = 1'b0;
    check("rst-mid accepted", 32'(acc_cnt - b_acc), 32'd1);
    for (int i = 0; i < 20 && (a_addr.size() - b_ack) < 2; i++) @(negedge clk);
    check("rst-mid two acks", 32'((a_addr.size() - b_ack) >= 2), 32'd1);
    @(posedge clk); #2;
    check("rst-mid rd_valid before", 32'(rd_valid), 32'd1);
    rst = 1'b1; #1;
    check("rst-mid cyc/stb/rd_valid", 32'({wb_cyc_o, wb_stb_o, rd_valid}), 32'd0);
    check("rst-mid cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst-mid no done/err", 32'((done_cnt - b_done) + (err_cnt - b_err)), 32'd0);
    snap();
    run_burst(1'b1, 26'h3F0, 8'd0, 4'hF, 32'hD0, -1, 0, outcome);
    check("post-rst outcome", 32'(outcome), 32'd0);
    compare_burst(1'b1, 26'h3F0, 8'd0, 4'hF, 32'hD0);
    check("post-rst mem", mem[8'hFC], 32'hD0);

    // cmd_valid held across three queued single-beat reads.
    snap();
    acc = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 26'h100; cmd_len = 8'd0; cmd_sel = 4'hF;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); hs = cmd_valid & cmd_ready;
      @(posedge clk); #1;
      if (hs) begin acc++; if (acc == 3) cmd_valid = 1'b0; end
      if (acc == 3 && (done_cnt - b_done) == 3) break;
    end
    cmd_valid = 1'b0;
    check("queued accepts", 32'(acc_cnt - b_acc), 32'd3);
    check("queued done pulses", 32'(done_cnt - b_done), 32'd3);
    check("queued cyc periods", 32'(cyc_periods - b_per), 32'd3);
    for (int i = b_gap + 1; i < gap_q.size(); i++)
      check($sformatf("queued gap%0d >=2", i - b_gap), 32'(gap_q[i] >= 2), 32'd1);
    check("queued rd count", 32'(rd_q.size() - b_rd), 32'd3);
    if (b_rd < rd_q.size()) check("queued rd data", rd_q[b_rd], 32'hA0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

endmodule
